// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one outstanding word fetch at a time,
// and buffers {pc, instruction} pairs toward decode; redirects flush everything in flight.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_KILL
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      pc_mem_q  [FIFO_DEPTH];
    logic [31:0]      ins_mem_q [FIFO_DEPTH];

    logic req_fire;
    logic push;
    logic pop;
    logic unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Request is gated by rst_n so nothing is offered to memory while reset is held.
    assign imem_req_valid = rst_n && (state_q == S_REQ) && !redirect_valid
                            && (count_q < CNT_W'(FIFO_DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign if_valid       = (count_q != '0);
    assign if_pc          = pc_mem_q[rd_ptr_q];
    assign if_instruction = ins_mem_q[rd_ptr_q];
    assign pop            = if_valid && if_ready;

    // Next-state logic for the fetch FSM and PC.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        push     = 1'b0;
        case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    push    = !redirect_valid;
                    state_d = S_REQ;
                end else if (redirect_valid) begin
                    state_d = S_KILL;
                end
            end
            S_KILL: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end
    end

    // FIFO pointer/count update; a redirect flush overrides any pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage resets to {0, NOP} so the head reads as a NOP out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem_q[i]  <= 32'h0;
                ins_mem_q[i] <= NOP;
            end
        end else if (push) begin
            pc_mem_q[wr_ptr_q]  <= req_pc_q;
            ins_mem_q[wr_ptr_q] <= imem_rsp_data;
        end
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage. It sits directly upstream of the instruction decoder and feeds it one 32-bit instruction word per handshake.
- Owns the program counter and issues word-aligned requests to instruction memory, which may have variable latency.
- Buffers {pc, instruction} pairs in a small FIFO and presents them to decode with valid/ready.
- Accepts branch/jump redirects from execute; a redirect flushes all in-flight and buffered fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset; bits [1:0] must be 0.
FIFO_DEPTH, 2, number of fetched {pc, instr} entries buffered toward decode; legal range 2..8.

Ports:
clk  input  1  Single clock; all state updates on the rising edge.
rst_n  input  1  Asynchronous, active-low reset.
imem_req_valid  output  1  Fetch request valid.
imem_req_ready  input  1  Memory accepts the request.
imem_req_addr  output  32  Fetch address (word aligned).
imem_rsp_valid  input  1  Response valid; exactly one response per accepted request, at least 1 cycle after acceptance.
imem_rsp_data  input  32  Instruction word.
redirect_valid  input  1  Redirect pulse from execute.
redirect_pc  input  32  Redirect target.
if_valid  output  1  FIFO head valid toward decode.
if_ready  input  1  Decode consumes the head.
if_pc  output  32  PC of the head instruction.
if_instruction  output  32  Head instruction word, consumed by the decoder.

Behaviour:
- Reset (async assert, sync deassert is the integrator's responsibility). While rst_n=0:
  - pc_q=RESET_PC, state=REQ, FIFO count=0.
  - Outputs: if_valid=0, imem_req_valid=0, if_pc=0, if_instruction=32'h0000_0013 (NOP), imem_req_addr=RESET_PC.
- Request side:
  - imem_req_addr=pc_q.
  - imem_req_valid=1 only when state=REQ, redirect_valid=0, and count<FIFO_DEPTH.
  - At most one request is outstanding.
  - Once imem_req_valid is asserted, it and the address stay stable until accepted. The only exception is a redirect, which may drop the request.
  - On handshake (valid&&ready): req_pc_q<=pc_q; pc_q<=pc_q+4, wrapping modulo 2^32 (0xFFFF_FFFC+4=0); state<=WAIT.
- State machine, states {REQ, WAIT, KILL}:
  - REQ: on handshake -> WAIT. On redirect -> stay in REQ with the new pc_q.
  - WAIT, rsp_valid and no redirect: push {req_pc_q, imem_rsp_data}, then -> REQ.
  - WAIT, redirect and no rsp_valid: -> KILL.
  - WAIT, redirect and rsp_valid in the same cycle: response discarded, -> REQ.
  - KILL, rsp_valid: discard the response, -> REQ. A redirect in the same cycle still updates pc_q.
  - KILL, redirect only: stay in KILL and update pc_q.
  - rsp_valid while in REQ is a protocol violation: ignored, no state change.
- Redirect, in the cycle redirect_valid=1:
  - pc_q<={redirect_pc[31:2],2'b00}; misaligned low bits are silently cleared.
  - FIFO flushed (count<=0); no push that cycle. if_valid is 0 from the next cycle.
  - A pop in the same cycle is allowed; the flush wins.
- FIFO:
  - Push on an accepted response; pop on if_valid&&if_ready. Simultaneous push and pop leaves count unchanged.
  - Request gating guarantees a push never occurs when full. Popping when empty is impossible (if_valid=0).
  - if_valid=(count!=0). if_pc and if_instruction come from the head entry and are registered.
  - While if_valid=1 and if_ready=0, the head values are held stable.
- Latency and throughput:
  - Request accepted in cycle N, response in N+k (k>=1): entry is visible with if_valid=1 in cycle N+k+1.
  - Next request may issue in cycle N+k+1.
  - Peak throughput is one instruction per k+1 cycles.
- Reset mid-operation: all state clears immediately. Any outstanding memory response arriving after reset release is ignored because state=REQ.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory returning addr^32'hA5A5_0000 -> first imem_req_addr=0x0. Decode sees if_pc 0x0,0x4,0x8 with matching data. One request per 2 cycles.
- if_ready=0 held -> after 2 entries (pcs 0x0,0x4) imem_req_valid stays 0. Raise if_ready -> entries drain in order, then fetching resumes at 0x8.
- imem_req_ready=0 for 3 cycles with a pending request -> imem_req_valid and addr=0x10 held stable. Accept on the 4th cycle -> next addr=0x14.
- Redirect to 0x100 while in WAIT, response arrives 2 cycles later -> response dropped, no if_valid, next request addr=0x100. FIFO previously holding 1 entry -> flushed.
- Redirect to 0x203 in the same cycle as rsp_valid -> response discarded, next request addr=0x200.
- Assert rst_n=0 mid-WAIT with 2 entries buffered -> if_valid=0, imem_req_valid=0 immediately. A late rsp_valid after release is ignored. First request addr=RESET_PC.
